// File: rtl/logic_box_cluster_if.sv
// Channel and configuration-scan bundle for one logic box cluster tile.
// The master side drives channel wires and the scan inputs; the slave side is the cluster.
interface logic_box_cluster_if #(
    parameter int W = 4,
    parameter int N = 2
);
    logic [W-1:0] left_in;
    logic [W-1:0] right_in;
    logic [W-1:0] up_in;
    logic [W-1:0] down_in;
    logic         cfg_en;
    logic         cfg_din;
    logic         cfg_load;
    logic         cfg_dout;
    logic         cfg_ready;
    logic         cfg_err;
    logic [N-1:0] left;
    logic [N-1:0] right;
    logic [N-1:0] up;
    logic [N-1:0] down;

    modport master (
        output left_in, right_in, up_in, down_in,
        output cfg_en, cfg_din, cfg_load,
        input  cfg_dout, cfg_ready, cfg_err,
        input  left, right, up, down
    );

    modport slave (
        input  left_in, right_in, up_in, down_in,
        input  cfg_en, cfg_din, cfg_load,
        output cfg_dout, cfg_ready, cfg_err,
        output left, right, up, down
    );
endinterface

// File: rtl/logic_box_cluster.sv
// Cluster of N K-input BLEs with serial shadow configuration and atomic commit.
// Optional macro LOGIC_BOX_FF_CE_EN adds a clock enable (ce) on the BLE flip-flops.
module logic_box_cluster #(
    parameter int K = 4,
    parameter int N = 2,
    parameter int W = 4
) (
    input logic clk,
    input logic reset,
`ifdef LOGIC_BOX_FF_CE_EN
    input logic ce,
`endif
    logic_box_cluster_if.slave bus
);
    localparam int SELW     = $clog2(4*W + N);
    localparam int LUTW     = 1 << K;
    localparam int BLEW     = K*SELW + LUTW + 1 + 4;
    localparam int CFG_BITS = N*BLEW;
    localparam int CNTW     = $clog2(CFG_BITS + 1);
    localparam int NPAD     = 1 << SELW;

    typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

    state_t                state, state_n;
    logic [CNTW-1:0]       count, count_n;
    logic [CFG_BITS-1:0]   shadow, shadow_n;
    logic [CFG_BITS-1:0]   active, active_n;
    logic                  err_q, err_n;
    logic [N-1:0]          ble_q;

    logic [NPAD-1:0]                src;
    logic [N-1:0][K-1:0][SELW-1:0]  sel;
    logic [N-1:0][K-1:0]            addr;
    logic [N-1:0][LUTW-1:0]         lut;
    logic [N-1:0]                   f, bo;
    logic [N-1:0]                   o_l, o_r, o_u, o_d;

    // Config state, counter, shadow, active and sticky error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            shadow <= '0;
            active <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            shadow <= shadow_n;
            active <= active_n;
            err_q  <= err_n;
        end
    end

    // Scan FSM: shift, wrap when full, commit only from FULL without a shift.
    always_comb begin
        state_n  = state;
        count_n  = count;
        shadow_n = shadow;
        active_n = active;
        err_n    = err_q;
        if (bus.cfg_load && (state != FULL || bus.cfg_en))
            err_n = 1'b1;
        unique case (state)
            IDLE, SHIFT: begin
                if (bus.cfg_en) begin
                    shadow_n = {bus.cfg_din, shadow[CFG_BITS-1:1]};
                    count_n  = count + CNTW'(1);
                    state_n  = (count_n == CNTW'(CFG_BITS)) ? FULL : SHIFT;
                end
            end
            FULL: begin
                if (bus.cfg_en) begin
                    shadow_n = {bus.cfg_din, shadow[CFG_BITS-1:1]};
                    count_n  = CNTW'(1);
                    state_n  = (CFG_BITS == 1) ? FULL : SHIFT;
                end else if (bus.cfg_load) begin
                    active_n = shadow;
                    count_n  = '0;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Sources past 4W+N are zero padding, so any select value is safe.
    assign src = NPAD'({ble_q, bus.down_in, bus.up_in,
                        bus.right_in, bus.left_in});

    // Per-BLE routing, LUT lookup, output mux and direction gating.
    always_comb begin
        sel  = '0;
        addr = '0;
        lut  = '0;
        f    = '0;
        bo   = '0;
        o_l  = '0;
        o_r  = '0;
        o_u  = '0;
        o_d  = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < K; j++) begin
                sel[i][j]  = active[BLEW*i + SELW*j +: SELW];
                addr[i][j] = src[sel[i][j]];
            end
            lut[i] = active[BLEW*i + K*SELW +: LUTW];
            f[i]   = lut[i][addr[i]];
            bo[i]  = active[BLEW*i + K*SELW + LUTW] ? ble_q[i] : f[i];
            o_l[i] = bo[i] & active[BLEW*i + BLEW - 4];
            o_r[i] = bo[i] & active[BLEW*i + BLEW - 3];
            o_u[i] = bo[i] & active[BLEW*i + BLEW - 2];
            o_d[i] = bo[i] & active[BLEW*i + BLEW - 1];
        end
    end

    // BLE flip-flops; feedback only ever comes from these registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ble_q <= '0;
        end else begin
`ifdef LOGIC_BOX_FF_CE_EN
            if (ce)
                ble_q <= f;
`else
            ble_q <= f;
`endif
        end
    end

    assign bus.left      = o_l;
    assign bus.right     = o_r;
    assign bus.up        = o_u;
    assign bus.down      = o_d;
    assign bus.cfg_dout  = shadow[0];
    assign bus.cfg_ready = (state == FULL);
    assign bus.cfg_err   = err_q;
endmodule

// File: tb/tb_logic_box_cluster.sv
// Bench for logic_box_cluster: directed plan steps plus randomized configs,
// checked against a field-level behavioural model of the cluster.
module tb_logic_box_cluster;
    localparam int K    = 4;
    localparam int N    = 2;
    localparam int W    = 4;
    localparam int SELW = 5;
    localparam int LUTW = 16;
    localparam int BLEW = 41;
    localparam int CFG  = 82;

    logic clk = 1'b0;
    logic reset;
`ifdef LOGIC_BOX_FF_CE_EN
    logic ce = 1'b1;
`endif

    always #5 clk = ~clk;

    logic_box_cluster_if #(.W(W), .N(N)) bus ();

    logic_box_cluster #(.K(K), .N(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef LOGIC_BOX_FF_CE_EN
        .ce    (ce),
`endif
        .bus   (bus)
    );

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    logic [CFG-1:0] m_shadow = '0;
    logic [CFG-1:0] m_active = '0;
    int             m_count  = 0;
    logic           m_err    = 1'b0;
    logic [N-1:0]   mq       = '0;

    logic [CFG-1:0] cfg_a, cfg_b, cfg_c, cfg_r;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [BLEW-1:0] ble_cfg(int s0, int s1, int s2,
        int s3, logic [15:0] l, logic ff, logic [3:0] dir);
        logic [BLEW-1:0] v;
        int s[4];
        s = '{s0, s1, s2, s3};
        v = '0;
        for (int j = 0; j < K; j++)
            v[SELW*j +: SELW] = SELW'(s[j]);
        v[K*SELW +: LUTW] = l;
        v[K*SELW + LUTW] = ff;
        v[BLEW-4 +: 4] = dir;
        return v;
    endfunction

    function automatic logic m_src(int s);
        if (s < W)         return bus.left_in[s];
        else if (s < 2*W)  return bus.right_in[s-W];
        else if (s < 3*W)  return bus.up_in[s-2*W];
        else if (s < 4*W)  return bus.down_in[s-3*W];
        else if (s < 4*W+N) return mq[s-4*W];
        return 1'b0;
    endfunction

    function automatic logic [N-1:0] m_f();
        logic [N-1:0] f;
        int a, base, s;
        f = '0;
        for (int i = 0; i < N; i++) begin
            base = BLEW*i;
            a = 0;
            for (int j = 0; j < K; j++) begin
                s = int'(m_active[base + SELW*j +: SELW]);
                if (m_src(s)) a += (1 << j);
            end
            f[i] = m_active[base + K*SELW + a];
        end
        return f;
    endfunction

    task automatic m_outs(output logic [N-1:0] l, output logic [N-1:0] r,
                          output logic [N-1:0] u, output logic [N-1:0] d);
        logic [N-1:0] f;
        logic [3:0] dir;
        logic b;
        f = m_f();
        l = '0; r = '0; u = '0; d = '0;
        for (int i = 0; i < N; i++) begin
            b = m_active[BLEW*i + K*SELW + LUTW] ? mq[i] : f[i];
            dir = m_active[BLEW*i + BLEW-4 +: 4];
            l[i] = b & dir[0];
            r[i] = b & dir[1];
            u[i] = b & dir[2];
            d[i] = b & dir[3];
        end
    endtask

    task automatic m_edge();
        logic [N-1:0] nf;
        nf = m_f();
        if (bus.cfg_load && (m_count != CFG || bus.cfg_en)) m_err = 1'b1;
        if (bus.cfg_en) begin
            m_shadow = {bus.cfg_din, m_shadow[CFG-1:1]};
            m_count = (m_count == CFG) ? 1 : m_count + 1;
        end else if (bus.cfg_load && m_count == CFG) begin
            m_active = m_shadow;
            m_count = 0;
        end
        mq = nf;
    endtask

    task automatic check_all(string tag);
        logic [N-1:0] l, r, u, d;
        m_outs(l, r, u, d);
        chk({tag, "/out"}, 32'({bus.left, bus.right, bus.up, bus.down}),
            32'({l, r, u, d}));
        chk({tag, "/cfg"}, 32'({bus.cfg_ready, bus.cfg_err, bus.cfg_dout}),
            32'({m_count == CFG, m_err, m_shadow[0]}));
    endtask

    task automatic set_in(logic [W-1:0] l, logic [W-1:0] r,
                          logic [W-1:0] u, logic [W-1:0] d);
        bus.left_in  = l;
        bus.right_in = r;
        bus.up_in    = u;
        bus.down_in  = d;
    endtask

    task automatic settle(string tag);
        #1;
        check_all(tag);
    endtask

    task automatic step(string tag);
        m_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic shift_range(logic [CFG-1:0] v, int lo, int hi, bit rnd);
        for (int b = lo; b < hi; b++) begin
            if (rnd) set_in(W'($urandom), W'($urandom),
                            W'($urandom), W'($urandom));
            bus.cfg_en  = 1'b1;
            bus.cfg_din = v[b];
            step("shift");
        end
        bus.cfg_en  = 1'b0;
        bus.cfg_din = 1'b0;
    endtask

    task automatic do_load(string tag);
        bus.cfg_load = 1'b1;
        step(tag);
        bus.cfg_load = 1'b0;
    endtask

    task automatic do_reset(string tag);
        #2 reset = 1'b0;
        m_shadow = '0;
        m_active = '0;
        m_count  = 0;
        m_err    = 1'b0;
        mq       = '0;
        #1;
        check_all(tag);
        chk({tag, "/zero"}, 32'({bus.left, bus.right, bus.up, bus.down,
            bus.cfg_ready, bus.cfg_err}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        set_in('0, '0, '0, '0);
        bus.cfg_en   = 1'b0;
        bus.cfg_din  = 1'b0;
        bus.cfg_load = 1'b0;
        #2;
        check_all("por");
        chk("por/zero", 32'({bus.left, bus.right, bus.up, bus.down,
            bus.cfg_ready, bus.cfg_err}), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        cfg_a = {41'd0, ble_cfg(0, 4, 31, 31, 16'h0006, 1'b0, 4'b0001)};
        cfg_b = {41'd0, ble_cfg(0, 4, 31, 31, 16'h0006, 1'b1, 4'b0001)};
        cfg_c = {ble_cfg(17, 31, 31, 31, 16'h5555, 1'b1, 4'b0100), 41'd0};

        // XOR, combinational output
        shift_range(cfg_a, 0, CFG-1, 1'b0);
        chk("ready81", 32'(bus.cfg_ready), 32'd0);
        shift_range(cfg_a, CFG-1, CFG, 1'b0);
        chk("ready82", 32'(bus.cfg_ready), 32'd1);
        do_load("load_a");
        chk("ready_after_load", 32'(bus.cfg_ready), 32'd0);
        set_in(4'd1, 4'd0, 4'd0, 4'd0);
        settle("xor10");
        chk("xor10_left", 32'(bus.left), 32'd1);
        chk("xor_others", 32'({bus.right, bus.up, bus.down}), 32'd0);
        set_in(4'd1, 4'd1, 4'd0, 4'd0);
        settle("xor11");
        chk("xor11_left", 32'(bus.left), 32'd0);
        step("xor_idle");

        // XOR, registered output
        shift_range(cfg_b, 0, CFG, 1'b0);
        do_load("load_b");
        step("b_hold");
        set_in(4'd1, 4'd0, 4'd0, 4'd0);
        settle("b_in");
        chk("b_before_edge", 32'(bus.left), 32'd0);
        step("b_edge");
        chk("b_after_edge", 32'(bus.left), 32'd1);
        set_in(4'd0, 4'd0, 4'd0, 4'd0);
        settle("b_in0");
        chk("b_hold1", 32'(bus.left), 32'd1);
        step("b_edge0");
        chk("b_after_edge0", 32'(bus.left), 32'd0);

        // Toggle through BLE1 feedback
        shift_range(cfg_c, 0, CFG, 1'b0);
        do_load("load_c");
        chk("tog0", 32'(bus.up[1]), 32'd0);
        for (int t = 1; t < 4; t++) begin
            step("tog");
            chk("tog_seq", 32'(bus.up[1]), 32'(t % 2));
        end

        // Premature load keeps the active config and sets the sticky error
        shift_range(cfg_a, 0, 40, 1'b0);
        do_load("early_load");
        chk("early_err", 32'(bus.cfg_err), 32'd1);
        step("early_keep");
        shift_range(cfg_a, 40, CFG, 1'b0);
        chk("late_ready", 32'(bus.cfg_ready), 32'd1);
        do_load("late_load");
        chk("late_err_sticky", 32'(bus.cfg_err), 32'd1);
        set_in(4'd1, 4'd0, 4'd0, 4'd0);
        settle("late_xor");
        chk("late_xor_left", 32'(bus.left), 32'd1);

        // Load attempted together with a shift
        shift_range(cfg_c, 0, CFG-1, 1'b0);
        bus.cfg_load = 1'b1;
        shift_range(cfg_c, CFG-1, CFG, 1'b0);
        bus.cfg_load = 1'b0;
        chk("load_with_en_keep", 32'(bus.left), 32'd1);

        // Asynchronous reset mid-shift, then a clean reload
        shift_range(cfg_c, 0, 30, 1'b0);
        do_reset("rst_mid");
        shift_range(cfg_a, 0, CFG, 1'b0);
        do_load("reload_a");
        chk("reload_err", 32'(bus.cfg_err), 32'd0);
        settle("reload_xor");
        chk("reload_xor_left", 32'(bus.left), 32'd1);

        // Random configurations, with channels moving while shifting
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < N; i++)
                cfg_r[BLEW*i +: BLEW] = ble_cfg(
                    int'($urandom_range(31)), int'($urandom_range(31)),
                    int'($urandom_range(31)), int'($urandom_range(31)),
                    16'($urandom), 1'($urandom), 4'($urandom));
            shift_range(cfg_r, 0, CFG, 1'b1);
            do_load("rnd_load");
            for (int c = 0; c < 12; c++) begin
                set_in(W'($urandom), W'($urandom),
                       W'($urandom), W'($urandom));
                settle("rnd_comb");
                step("rnd_edge");
            end
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
